// File: rtl/i2c_cfg_target_m_pkg.sv
// Shared types and constants for the I2C config-register target: FSM state
// encodings, ACK/NACK bus levels, default device address, pin event bundle.
package i2c_cfg_target_m_pkg;

   localparam logic [6:0] I2C_DEV_ADDR_DFLT = 7'h2C;
   localparam logic       I2C_ACK           = 1'b0;
   localparam logic       I2C_NACK          = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_e;

   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
   } pin_evt_t;

endpackage

// File: rtl/i2c_cfg_target_m_if.sv
// Open-drain I2C pin bundle: raw scl/sda levels in, sda pull-down request out.
interface i2c_cfg_target_m_if;
   logic scl_in;
   logic sda_in;
   logic sda_pull;

   modport slave  (input scl_in, input sda_in, output sda_pull);
   modport master (output scl_in, output sda_in, input sda_pull);
endinterface

// File: rtl/i2c_pin_sync_m.sv
// One I2C pin: synchroniser, optional 3-sample majority filter (I2C_GLITCH_FILTER_EN),
// history flop and single-cycle rise/fall pulses.
module i2c_pin_sync_m
   import i2c_cfg_target_m_pkg::*;
#(
   parameter int SYNC_STG = 2
) (
   input  logic     hsclk,
   input  logic     resetb,
   input  logic     pin_i,
   output pin_evt_t evt_o
);

   logic [SYNC_STG-1:0] sync_q;
   logic                lvl;
   logic                hist_q;

   // Reset to 1 so an idle (pulled-up) bus produces no edge on reset release.
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) sync_q <= '1;
      else         sync_q <= {sync_q[SYNC_STG-2:0], pin_i};
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] win_q;
   logic       flt_q;
   logic       smp;

   assign smp = sync_q[SYNC_STG-1];

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         win_q <= '1;
         flt_q <= 1'b1;
      end else begin
         win_q <= {win_q[0], smp};
         flt_q <= (smp & win_q[0]) | (smp & win_q[1]) | (win_q[0] & win_q[1]);
      end
   end

   assign lvl = flt_q;
`else
   assign lvl = sync_q[SYNC_STG-1];
`endif

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) hist_q <= 1'b1;
      else         hist_q <= lvl;
   end

   assign evt_o.lvl  = lvl;
   assign evt_o.rise = lvl & ~hist_q;
   assign evt_o.fall = ~lvl & hist_q;

endmodule

// File: rtl/i2c_cfg_target_m.sv
// I2C target exposing NREGS config bytes (top index reads status_in, writes dropped).
// Optional input glitch filter: define I2C_GLITCH_FILTER_EN.
module i2c_cfg_target_m
   import i2c_cfg_target_m_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DFLT,
   parameter int         NREGS    = 4,
   parameter int         SYNC_STG = 2
) (
   input  logic                 hsclk,
   input  logic                 resetb,
   i2c_cfg_target_m_if.slave    bus,
   input  logic [7:0]           status_in,
   output logic [8*NREGS-1:0]   regs_out,
   output logic                 wr_stb,
   output logic [2:0]           wr_idx,
   output logic                 busy
);

   localparam int             PW   = $clog2(NREGS);
   localparam logic [PW-1:0]  LAST = PW'(NREGS - 1);

   pin_evt_t scl, sda;

   i2c_pin_sync_m #(.SYNC_STG(SYNC_STG)) u_scl (
      .hsclk(hsclk), .resetb(resetb), .pin_i(bus.scl_in), .evt_o(scl));
   i2c_pin_sync_m #(.SYNC_STG(SYNC_STG)) u_sda (
      .hsclk(hsclk), .resetb(resetb), .pin_i(bus.sda_in), .evt_o(sda));

   // An SCL edge in the same sample masks START/STOP.
   logic scl_edge, start, stop;
   assign scl_edge = scl.rise | scl.fall;
   assign start    = sda.fall & scl.lvl & ~scl_edge;
   assign stop     = sda.rise & scl.lvl & ~scl_edge;

   state_e                  state_q, state_d;
   logic [7:0]              sh_q, sh_d;
   logic [2:0]              bcnt_q, bcnt_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [NREGS-1:0][7:0]   regs_q, regs_d;
   logic                    pull_q, pull_d;
   logic                    stb_q, stb_d;
   logic [2:0]              idx_q, idx_d;
   logic                    busy_q, busy_d;
   logic                    rw_q, rw_d;
   logic                    ld_q, ld_d;

   logic [7:0] byte_in, rd_byte;
   logic       last_bit;
   assign byte_in  = {sh_q[6:0], sda.lvl};
   assign rd_byte  = (ptr_q == LAST) ? status_in : regs_q[ptr_q];
   assign last_bit = (bcnt_q == 3'd7);

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         bcnt_q  <= '0;
         ptr_q   <= '0;
         regs_q  <= '0;
         pull_q  <= 1'b0;
         stb_q   <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         rw_q    <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcnt_q  <= bcnt_d;
         ptr_q   <= ptr_d;
         regs_q  <= regs_d;
         pull_q  <= pull_d;
         stb_q   <= stb_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         rw_q    <= rw_d;
         ld_q    <= ld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcnt_d  = bcnt_q;
      ptr_d   = ptr_q;
      regs_d  = regs_q;
      pull_d  = pull_q;
      stb_d   = 1'b0;
      idx_d   = idx_q;
      busy_d  = busy_q;
      rw_d    = rw_q;
      ld_d    = ld_q;

      if (start) begin
         state_d = ST_ADDR;
         bcnt_d  = '0;
         busy_d  = 1'b1;
         pull_d  = 1'b0;
         ld_d    = 1'b0;
      end else if (stop) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         pull_d  = 1'b0;
         ld_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl.rise) begin
                  sh_d   = byte_in;
                  bcnt_d = bcnt_q + 3'd1;
                  if (last_bit) begin
                     case (state_q)
                        ST_ADDR: begin
                           rw_d    = sda.lvl;
                           state_d = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                        ST_PTR: begin
                           ptr_d   = byte_in[PW-1:0];
                           state_d = ST_PTR_ACK;
                        end
                        default: begin
                           // Top index has no storage: ACK the byte but drop it.
                           if (ptr_q != LAST) begin
                              regs_d[ptr_q] = byte_in;
                              stb_d         = 1'b1;
                              idx_d         = 3'(ptr_q);
                           end
                           ptr_d   = ptr_q + 1'b1;
                           state_d = ST_WDATA_ACK;
                        end
                     endcase
                  end
               end
            end
            // First fall opens the ACK slot, second fall closes it.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl.fall) begin
                  if (!pull_q) begin
                     pull_d = 1'b1;
                  end else begin
                     pull_d = 1'b0;
                     bcnt_d = '0;
                     if (state_q == ST_ADDR_ACK && rw_q) begin
                        sh_d    = {rd_byte[6:0], 1'b0};
                        pull_d  = ~rd_byte[7];
                        state_d = ST_RDATA;
                     end else begin
                        state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl.rise) begin
                  bcnt_d = bcnt_q + 3'd1;
                  if (last_bit) state_d = ST_RDATA_ACK;
               end else if (scl.fall) begin
                  pull_d = ~sh_q[7];
                  sh_d   = {sh_q[6:0], 1'b0};
               end
            end
            // ld_q separates the release fall from the next-byte load fall.
            ST_RDATA_ACK: begin
               if (scl.fall) begin
                  if (ld_q) begin
                     ld_d    = 1'b0;
                     sh_d    = {rd_byte[6:0], 1'b0};
                     pull_d  = ~rd_byte[7];
                     bcnt_d  = '0;
                     state_d = ST_RDATA;
                  end else begin
                     pull_d = 1'b0;
                  end
               end else if (scl.rise) begin
                  if (sda.lvl == I2C_NACK) begin
                     state_d = ST_IGNORE;
                  end else begin
                     ptr_d = ptr_q + 1'b1;
                     ld_d  = 1'b1;
                  end
               end
            end
            default: pull_d = 1'b0;
         endcase
      end
   end

   assign bus.sda_pull = pull_q;
   assign regs_out     = regs_q;
   assign wr_stb       = stb_q;
   assign wr_idx       = idx_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_cfg_target_m.sv
// Directed bench for i2c_cfg_target_m: bit-banged controller plus a wr_stb scoreboard.
module tb_i2c_cfg_target_m;
   import i2c_cfg_target_m_pkg::*;

   localparam int NREGS = 4;
   localparam int Q     = 10;

`ifdef I2C_GLITCH_FILTER_EN
   localparam logic [7:0] G_DATA = 8'hA5;
   localparam logic       G_ACK  = I2C_ACK;
`else
   localparam logic [7:0] G_DATA = 8'hD2;
   localparam logic       G_ACK  = I2C_NACK;
`endif

   typedef struct {
      int         idx;
      logic [7:0] data;
   } wr_exp_t;

   logic                hsclk = 1'b0;
   logic                resetb = 1'b0;
   logic                scl_drv = 1'b1;
   logic                sda_drv = 1'b1;
   logic [7:0]          status_in = 8'h00;
   logic [8*NREGS-1:0]  regs_out;
   logic                wr_stb;
   logic [2:0]          wr_idx;
   logic                busy;

   wr_exp_t exp_wr[$];
   int      nvec = 0;
   int      nerr = 0;
   int      pull_cnt = 0;

   i2c_cfg_target_m_if bus();
   assign bus.scl_in = scl_drv;
   assign bus.sda_in = sda_drv & ~bus.sda_pull;

   i2c_cfg_target_m #(.DEV_ADDR(7'h2C), .NREGS(NREGS), .SYNC_STG(2)) dut (
      .hsclk(hsclk), .resetb(resetb), .bus(bus), .status_in(status_in),
      .regs_out(regs_out), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy));

   always #5 hsclk = ~hsclk;

   task automatic hw(input int n);
      repeat (n) @(negedge hsclk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clk_bit(input logic b, input bit glitch, output logic smp);
      sda_drv = b; hw(Q);
      scl_drv = 1'b1; hw(Q);
      smp = bus.sda_in;
      if (glitch) begin
         hw(4); scl_drv = 1'b0; hw(1); scl_drv = 1'b1; hw(Q-5);
      end else begin
         hw(Q);
      end
      scl_drv = 1'b0; hw(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], (7 - i) == gbit, s);
      clk_bit(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, 1'b0, s);
         d = {d[6:0], s};
      end
      clk_bit(ack_bit, 1'b0, s);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; hw(Q);
      scl_drv = 1'b1; hw(Q);
      sda_drv = 1'b0; hw(Q);
      scl_drv = 1'b0; hw(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; hw(Q);
      scl_drv = 1'b1; hw(Q);
      sda_drv = 1'b1; hw(Q);
   endtask

   initial begin
      logic       a;
      logic       s;
      logic [7:0] d;
      int         p0;

      fork
         begin : monitor
            wr_exp_t e;
            forever begin
               @(negedge hsclk);
               if (bus.sda_pull === 1'b1) pull_cnt++;
               if (resetb && wr_stb === 1'b1) begin
                  nvec++;
                  if (exp_wr.size() == 0) begin
                     nerr++;
                     $display("FAIL wr_stb: unexpected write idx=%0d, no write expected", wr_idx);
                  end else begin
                     e = exp_wr.pop_front();
                     if (wr_idx !== 3'(e.idx) || regs_out[8*e.idx +: 8] !== e.data) begin
                        nerr++;
                        $display("FAIL wr_stb: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                                 wr_idx, regs_out[8*e.idx +: 8], e.idx, e.data);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      hw(3);
      chk("rst regs_out", regs_out, 0);
      chk("rst sda_pull", bus.sda_pull, 0);
      chk("rst wr_stb", wr_stb, 0);
      chk("rst wr_idx", wr_idx, 0);
      chk("rst busy", busy, 0);
      resetb = 1'b1; hw(5);

      // 1: write 0xA5 to reg1
      i2c_start();
      chk("t1 busy", busy, 1);
      send_byte(8'h58, -1, a); chk("t1 addr ack", a, I2C_ACK);
      send_byte(8'h01, -1, a); chk("t1 ptr ack", a, I2C_ACK);
      exp_wr.push_back('{idx: 1, data: 8'hA5});
      send_byte(8'hA5, -1, a); chk("t1 data ack", a, I2C_ACK);
      i2c_stop(); hw(Q);
      chk("t1 reg1", regs_out[15:8], 8'hA5);
      chk("t1 busy after stop", busy, 0);

      // 2: ptr=1, repeated START, read two bytes
      i2c_start();
      send_byte(8'h58, -1, a); chk("t2 addr ack", a, I2C_ACK);
      send_byte(8'h01, -1, a); chk("t2 ptr ack", a, I2C_ACK);
      i2c_start();
      send_byte(8'h59, -1, a); chk("t2 raddr ack", a, I2C_ACK);
      read_byte(I2C_ACK, d);   chk("t2 rd0", d, 8'hA5);
      read_byte(I2C_NACK, d);  chk("t2 rd1", d, 8'h00);
      chk("t2 released after nack", bus.sda_pull, 0);
      i2c_stop(); hw(Q);
      chk("t2 busy after stop", busy, 0);

      // 3: wrong address
      p0 = pull_cnt;
      i2c_start();
      send_byte(8'h5A, -1, a); chk("t3 addr nack", a, I2C_NACK);
      chk("t3 busy", busy, 1);
      send_byte(8'h00, -1, a); chk("t3 data nack", a, I2C_NACK);
      i2c_stop(); hw(Q);
      chk("t3 no sda drive", pull_cnt - p0, 0);
      chk("t3 busy after stop", busy, 0);
      chk("t3 regs", regs_out, 32'h0000A500);

      // 4: pointer wrap across the status slot, then read status
      i2c_start();
      send_byte(8'h58, -1, a); chk("t4 addr ack", a, I2C_ACK);
      send_byte(8'h02, -1, a); chk("t4 ptr ack", a, I2C_ACK);
      exp_wr.push_back('{idx: 2, data: 8'h11});
      send_byte(8'h11, -1, a); chk("t4 d0 ack", a, I2C_ACK);
      send_byte(8'h22, -1, a); chk("t4 d1 ack", a, I2C_ACK);
      exp_wr.push_back('{idx: 0, data: 8'h33});
      send_byte(8'h33, -1, a); chk("t4 d2 ack", a, I2C_ACK);
      i2c_stop(); hw(Q);
      chk("t4 regs", regs_out, 32'h0011A533);
      status_in = 8'h7E;
      i2c_start();
      send_byte(8'h58, -1, a);
      send_byte(8'h03, -1, a);
      i2c_start();
      send_byte(8'h59, -1, a); chk("t4 raddr ack", a, I2C_ACK);
      read_byte(I2C_NACK, d);  chk("t4 status read", d, 8'h7E);
      i2c_stop(); hw(Q);

      // 5a: STOP after 5 data bits
      i2c_start();
      send_byte(8'h58, -1, a);
      send_byte(8'h01, -1, a);
      for (int i = 0; i < 5; i++) clk_bit(1'b1, 1'b0, s);
      i2c_stop(); hw(Q);
      chk("t5 regs after abort", regs_out, 32'h0011A533);
      chk("t5 busy after abort", busy, 0);

      // 5b: reset while driving a read bit (reg0=0x33, MSB 0 -> pulled)
      i2c_start();
      send_byte(8'h58, -1, a);
      send_byte(8'h00, -1, a);
      i2c_start();
      send_byte(8'h59, -1, a); chk("t5 raddr ack", a, I2C_ACK);
      chk("t5 driving bit7", bus.sda_pull, 1);
      resetb = 1'b0; #1;
      chk("t5 reset releases sda", bus.sda_pull, 0);
      chk("t5 reset regs", regs_out, 0);
      chk("t5 reset busy", busy, 0);
      hw(3); resetb = 1'b1; hw(3);
      i2c_stop(); hw(Q);

      // 6: 1-hsclk SCL low glitch during data MSB
      i2c_start();
      send_byte(8'h58, -1, a);
      send_byte(8'h00, -1, a);
      exp_wr.push_back('{idx: 0, data: G_DATA});
      send_byte(8'hA5, 0, a); chk("t6 glitch ack", a, G_ACK);
      i2c_stop(); hw(Q);
      chk("t6 regs", regs_out, {24'h0, G_DATA});
      chk("t6 busy", busy, 0);

      hw(4);
      chk("pending writes", exp_wr.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
